// File: rtl/triad_frame_packer_pkg.sv
// Shared definitions for the triad frame packer: state encoding and frame geometry.
package triad_frame_packer_pkg;

   localparam int FRAME_LEN     = 12;
   localparam int PAYLOAD_BYTES = 9;
   localparam int PAD_W         = 4;
   localparam int TRIAD_W       = 68;
   localparam int PAYLOAD_W     = 8 * PAYLOAD_BYTES;
   localparam int IDX_W         = 4;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BYTES - 1);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_HDR0     = 3'd1,
      ST_HDR1     = 3'd2,
      ST_PAYLOAD  = 3'd3,
      ST_CHECKSUM = 3'd4
   } state_t;

endpackage

// File: rtl/triad_frame_packer.sv
// Latches a 68-bit triad sample and streams it as a 12-byte frame:
// sync header, zero-padded payload (MSB byte first), XOR checksum of the payload.
//
// state       | meaning
// ------------+--------------------------------------------------
// ST_IDLE     | waiting for data_avl, byte_valid low
// ST_HDR0     | driving SYNC0
// ST_HDR1     | driving SYNC1
// ST_PAYLOAD  | driving payload byte idx (0..8) from shift register top
// ST_CHECKSUM | driving XOR of the nine payload bytes
module triad_frame_packer
   import triad_frame_packer_pkg::*;
#(
   parameter logic [7:0] SYNC0 = 8'hA5,
   parameter logic [7:0] SYNC1 = 8'h5A
) (
   input  logic               clk_96MHz,
   input  logic               reset,
   input  logic               data_avl,
   input  logic [TRIAD_W-1:0] triad_data,
   output logic               reset_parser,
   output logic [7:0]         byte_out,
   output logic               byte_valid,
   input  logic               byte_ready,
   output logic               busy,
   output logic [7:0]         dropped_count
);

   state_t                 state, state_n;
   logic [IDX_W-1:0]       idx, idx_n;
   logic [PAYLOAD_W-1:0]   shreg, shreg_n;
   logic [7:0]             csum, csum_n;
   logic [7:0]             byte_out_n;
   logic                   byte_valid_n;
   logic                   reset_parser_n;
   logic                   busy_n;
   logic [7:0]             dropped_n;
   logic                   accept;

   assign accept = byte_valid & byte_ready;

   always_ff @(posedge clk_96MHz) begin
      if (reset) begin
         state         <= ST_IDLE;
         idx           <= '0;
         shreg         <= '0;
         csum          <= '0;
         byte_out      <= 8'h00;
         byte_valid    <= 1'b0;
         reset_parser  <= 1'b0;
         busy          <= 1'b0;
         dropped_count <= 8'h00;
      end else begin
         state         <= state_n;
         idx           <= idx_n;
         shreg         <= shreg_n;
         csum          <= csum_n;
         byte_out      <= byte_out_n;
         byte_valid    <= byte_valid_n;
         reset_parser  <= reset_parser_n;
         busy          <= busy_n;
         dropped_count <= dropped_n;
      end
   end

   always_comb begin
      state_n        = state;
      idx_n          = idx;
      shreg_n        = shreg;
      csum_n         = csum;
      byte_out_n     = byte_out;
      byte_valid_n   = byte_valid;
      reset_parser_n = 1'b0;
      dropped_n      = dropped_count;

      // Any sample offered while a frame is in flight is lost, including the
      // cycle in which the checksum is accepted.
      if (data_avl && (state != ST_IDLE) && (dropped_count != 8'hFF))
         dropped_n = dropped_count + 8'h01;

      case (state)
         ST_IDLE: begin
            if (data_avl) begin
               shreg_n        = {{PAD_W{1'b0}}, triad_data};
               csum_n         = 8'h00;
               idx_n          = '0;
               state_n        = ST_HDR0;
               byte_out_n     = SYNC0;
               byte_valid_n   = 1'b1;
               reset_parser_n = 1'b1;
            end
         end
         ST_HDR0: begin
            if (accept) begin
               state_n    = ST_HDR1;
               byte_out_n = SYNC1;
            end
         end
         ST_HDR1: begin
            if (accept) begin
               state_n    = ST_PAYLOAD;
               idx_n      = '0;
               byte_out_n = shreg[PAYLOAD_W-1 -: 8];
            end
         end
         ST_PAYLOAD: begin
            if (accept) begin
               csum_n  = csum ^ byte_out;
               shreg_n = shreg << 8;
               if (idx == LAST_IDX) begin
                  state_n    = ST_CHECKSUM;
                  byte_out_n = csum ^ byte_out;
               end else begin
                  idx_n      = idx + 1'b1;
                  byte_out_n = shreg[PAYLOAD_W-9 -: 8];
               end
            end
         end
         ST_CHECKSUM: begin
            if (accept) begin
               state_n      = ST_IDLE;
               byte_valid_n = 1'b0;
               byte_out_n   = 8'h00;
            end
         end
         default: begin
            state_n      = ST_IDLE;
            byte_valid_n = 1'b0;
         end
      endcase

      busy_n = (state_n != ST_IDLE);
   end

endmodule

// File: tb/tb_triad_frame_packer.sv
// Directed bench for triad_frame_packer: frame content, checksum, backpressure,
// overrun counting, mid-frame reset and the checksum/next-sample boundary.
module tb_triad_frame_packer;

   logic        clk_96MHz;
   logic        reset;
   logic        data_avl;
   logic [67:0] triad_data;
   logic        reset_parser;
   logic [7:0]  byte_out;
   logic        byte_valid;
   logic        byte_ready;
   logic        busy;
   logic [7:0]  dropped_count;

   int errors = 0;
   int checks = 0;

   logic [7:0] exp_a [12] = '{8'hA5, 8'h5A, 8'h00, 8'h12, 8'h34, 8'h56,
                              8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h00};
   logic [7:0] exp_f [12] = '{8'hA5, 8'h5A, 8'h0F, 8'hFF, 8'hFF, 8'hFF,
                              8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F};

   localparam logic [67:0] DATA_A = 68'h0123456789ABCDEF0;
   localparam logic [67:0] DATA_F = 68'hFFFFFFFFFFFFFFFFF;

   triad_frame_packer dut (
      .clk_96MHz     (clk_96MHz),
      .reset         (reset),
      .data_avl      (data_avl),
      .triad_data    (triad_data),
      .reset_parser  (reset_parser),
      .byte_out      (byte_out),
      .byte_valid    (byte_valid),
      .byte_ready    (byte_ready),
      .busy          (busy),
      .dropped_count (dropped_count)
   );

   initial begin
      clk_96MHz = 1'b0;
      forever #5 clk_96MHz = ~clk_96MHz;
   end

   task automatic tick();
      @(posedge clk_96MHz);
      #1;
   endtask

   task automatic pulse(input logic [67:0] d);
      triad_data = d;
      data_avl   = 1'b1;
      tick();
      data_avl   = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      checks++;
      if ({reset_parser, byte_valid, busy} !== 3'b000 || byte_out !== 8'h00 ||
          dropped_count !== 8'h00) begin
         errors++;
         $display("FAIL reset_state: rp=%b valid=%b busy=%b byte=%h drop=%h, want 0 0 0 00 00",
                  reset_parser, byte_valid, busy, byte_out, dropped_count);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_frame_content();
      byte_ready = 1'b1;
      pulse(DATA_A);
      for (int k = 0; k < 12; k++) begin
         checks++;
         if (byte_valid !== 1'b1 || byte_out !== exp_a[k] || busy !== 1'b1) begin
            errors++;
            $display("FAIL frame_byte[%0d]: valid=%b busy=%b byte=%h, want 1 1 %h",
                     k, byte_valid, busy, byte_out, exp_a[k]);
         end
         checks++;
         if (reset_parser !== (k == 0)) begin
            errors++;
            $display("FAIL reset_parser[%0d]: got %b, want %b", k, reset_parser, (k == 0));
         end
         tick();
      end
      checks++;
      if (byte_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL frame_end: valid=%b busy=%b, want 0 0", byte_valid, busy);
      end
   endtask

   task automatic test_checksum();
      byte_ready = 1'b1;
      pulse(DATA_F);
      for (int k = 0; k < 12; k++) begin
         checks++;
         if (byte_valid !== 1'b1 || byte_out !== exp_f[k]) begin
            errors++;
            $display("FAIL checksum_frame[%0d]: valid=%b byte=%h, want 1 %h",
                     k, byte_valid, byte_out, exp_f[k]);
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] lfsr = 8'hB7;
      logic       prev_stall = 1'b0;
      logic [7:0] prev_byte = 8'h00;
      int         cnt = 0;
      pulse(DATA_A);
      for (int cyc = 0; cyc < 300 && cnt < 12; cyc++) begin
         lfsr       = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
         byte_ready = lfsr[0];
         checks++;
         if (byte_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_valid_dropped: cyc=%0d valid=%b, want 1", cyc, byte_valid);
         end
         if (prev_stall) begin
            checks++;
            if (byte_out !== prev_byte) begin
               errors++;
               $display("FAIL bp_hold: cyc=%0d byte=%h, want %h", cyc, byte_out, prev_byte);
            end
         end
         if (byte_ready) begin
            checks++;
            if (byte_out !== exp_a[cnt]) begin
               errors++;
               $display("FAIL bp_byte[%0d]: got %h, want %h", cnt, byte_out, exp_a[cnt]);
            end
            cnt++;
         end
         prev_stall = !byte_ready;
         prev_byte  = byte_out;
         tick();
      end
      checks++;
      if (cnt != 12 || byte_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_complete: accepted=%0d valid=%b, want 12 0", cnt, byte_valid);
      end
      byte_ready = 1'b1;
   endtask

   task automatic test_overrun();
      int rp_seen = 0;
      byte_ready = 1'b1;
      pulse(DATA_A);
      for (int k = 0; k < 14; k++) begin
         if (reset_parser === 1'b1) rp_seen++;
         data_avl   = (k == 4);
         triad_data = DATA_F;
         tick();
      end
      data_avl = 1'b0;
      checks++;
      if (rp_seen != 1 || dropped_count !== 8'h01) begin
         errors++;
         $display("FAIL overrun_single: rp_pulses=%0d drop=%h, want 1 01", rp_seen, dropped_count);
      end
      // Stall the frame and hold data_avl high for 300 cycles.
      byte_ready = 1'b0;
      pulse(DATA_A);
      data_avl = 1'b1;
      for (int k = 0; k < 300; k++) begin
         tick();
         if (k == 9) begin
            checks++;
            if (dropped_count !== 8'h0B) begin
               errors++;
               $display("FAIL overrun_count10: got %h, want 0b", dropped_count);
            end
         end
      end
      data_avl = 1'b0;
      checks++;
      if (dropped_count !== 8'hFF || byte_out !== 8'hA5 || byte_valid !== 1'b1) begin
         errors++;
         $display("FAIL overrun_saturate: drop=%h byte=%h valid=%b, want ff a5 1",
                  dropped_count, byte_out, byte_valid);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      byte_ready = 1'b1;
   endtask

   task automatic test_reset_mid_frame();
      byte_ready = 1'b1;
      pulse(DATA_A);
      for (int k = 0; k < 6; k++) begin
         data_avl = (k == 2);
         tick();
      end
      data_avl = 1'b0;
      checks++;
      if (byte_out !== 8'h78 || dropped_count !== 8'h01) begin
         errors++;
         $display("FAIL mid_frame_pre: byte=%h drop=%h, want 78 01", byte_out, dropped_count);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (byte_valid !== 1'b0 || busy !== 1'b0 || dropped_count !== 8'h00) begin
         errors++;
         $display("FAIL mid_frame_reset: valid=%b busy=%b drop=%h, want 0 0 00",
                  byte_valid, busy, dropped_count);
      end
      tick();
      pulse(DATA_A);
      for (int k = 0; k < 12; k++) begin
         checks++;
         if (byte_valid !== 1'b1 || byte_out !== exp_a[k]) begin
            errors++;
            $display("FAIL post_reset_frame[%0d]: valid=%b byte=%h, want 1 %h",
                     k, byte_valid, byte_out, exp_a[k]);
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      byte_ready = 1'b1;
      pulse(DATA_A);
      for (int k = 0; k < 11; k++) tick();
      checks++;
      if (byte_out !== 8'h00 || byte_valid !== 1'b1 || dropped_count !== 8'h00) begin
         errors++;
         $display("FAIL b2b_at_checksum: byte=%h valid=%b drop=%h, want 00 1 00",
                  byte_out, byte_valid, dropped_count);
      end
      pulse(DATA_F);
      checks++;
      if (byte_valid !== 1'b0 || busy !== 1'b0 || dropped_count !== 8'h01 ||
          reset_parser !== 1'b0) begin
         errors++;
         $display("FAIL b2b_drop: valid=%b busy=%b drop=%h rp=%b, want 0 0 01 0",
                  byte_valid, busy, dropped_count, reset_parser);
      end
      pulse(DATA_F);
      for (int k = 0; k < 12; k++) begin
         checks++;
         if (byte_valid !== 1'b1 || byte_out !== exp_f[k] || reset_parser !== (k == 0)) begin
            errors++;
            $display("FAIL b2b_frame[%0d]: valid=%b byte=%h rp=%b, want 1 %h %b",
                     k, byte_valid, byte_out, reset_parser, exp_f[k], (k == 0));
         end
         tick();
      end
      checks++;
      if (busy !== 1'b0 || dropped_count !== 8'h01) begin
         errors++;
         $display("FAIL b2b_end: busy=%b drop=%h, want 0 01", busy, dropped_count);
      end
   endtask

   initial begin
      reset      = 1'b1;
      data_avl   = 1'b0;
      triad_data = '0;
      byte_ready = 1'b1;
      test_reset();
      test_frame_content();
      test_checksum();
      test_backpressure();
      test_overrun();
      test_reset_mid_frame();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
